// File: rtl/rv32i_uart_ctrl_pkg.sv
// Shared definitions for the rv32i_uart CPU-side controller: register word
// indices, STATUS/CTRL bit positions and the TX launch FSM state encoding.
package rv32i_uart_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_IDLE    = 5;
  localparam int ST_RX_CNT_LSB = 8;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_GUARD  = 2'd2,
    TX_WAIT   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/rv32i_uart_ctrl_fifo.sv
// Synchronous byte FIFO used for both the TX and RX queues.
// Ports:
//   clk, rst        clock and synchronous active-high reset (pointers/count only)
//   push, wdata     write request and data; ignored when full unless a pop
//                   happens on the same edge
//   pop             read request; ignored when empty
//   full, empty     occupancy flags
//   count           entries held, 0..DEPTH (AW+1 bits)
//   head            oldest entry, valid when not empty
module rv32i_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign head    = mem[rptr];
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries data only and is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/rv32i_uart_ctrl.sv
// CPU-side controller for the rv32i_uart byte interface. Queues CPU bytes for
// transmission, queues received bytes for the CPU, exposes DATA/STATUS/CTRL
// registers on a simple strobe bus and drives a level interrupt.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bus_sel/we/addr/wdata     one-cycle bus request (addr is a word index)
//   bus_rdata, bus_ready      registered response, the cycle after bus_sel
//   uart_rx_data/valid        received byte strobe from the UART
//   uart_tx_data/valid        byte launch strobe to the UART
//   uart_tx_ready             UART able to accept a byte
//   irq                       registered level interrupt
module rv32i_uart_ctrl
  import rv32i_uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic        irq
);

  logic wr_req;
  logic rd_req;
  assign wr_req = bus_sel & bus_we;
  assign rd_req = bus_sel & ~bus_we;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [FIFO_AW:0] tx_count;
  logic [7:0]       tx_head;
  logic             rx_pop, rx_full, rx_empty;
  logic [FIFO_AW:0] rx_count;
  logic [7:0]       rx_head;

  tx_state_e  tx_state;
  logic [1:0] ctrl;
  logic       rx_overrun;
  logic       ovr_set;
  logic       ovr_clr;
  logic [31:0] status_word;
  logic [31:0] rdata_nxt;
  logic        wdata_unused;

  assign wdata_unused = ^{bus_wdata[31:5], bus_wdata[3:2]};

  assign tx_push = wr_req && (bus_addr == REG_DATA);
  assign rx_pop  = rd_req && (bus_addr == REG_DATA);
  // Pop happens on the edge that enters LAUNCH, together with capturing the head.
  assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty && uart_tx_ready;

  // A full RX FIFO accepts the new byte only if the CPU pops on the same edge.
  assign ovr_set = uart_rx_valid && rx_full && !rx_pop;
  assign ovr_clr = wr_req && (bus_addr == REG_STATUS) && bus_wdata[ST_RX_OVERRUN];

  rv32i_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (bus_wdata[7:0]),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  rv32i_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rx_valid),
    .wdata (uart_rx_data),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_TX_EMPTY]   = tx_empty;
    status_word[ST_RX_EMPTY]   = rx_empty;
    status_word[ST_RX_FULL]    = rx_full;
    status_word[ST_RX_OVERRUN] = rx_overrun;
    status_word[ST_TX_IDLE]    = (tx_state == TX_IDLE) && (tx_count == '0);
    status_word[ST_RX_CNT_LSB +: FIFO_AW+1] = rx_count;
  end

  always_comb begin
    rdata_nxt = '0;
    if (rd_req) begin
      case (bus_addr)
        REG_DATA:   if (!rx_empty) rdata_nxt[7:0] = rx_head;
        REG_STATUS: rdata_nxt = status_word;
        REG_CTRL:   rdata_nxt[1:0] = ctrl;
        default:    ;
      endcase
    end
  end

  // Bus response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= bus_sel;
      bus_rdata <= rdata_nxt;
    end
  end

  // Control registers and interrupt stage
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      rx_overrun <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_req && (bus_addr == REG_CTRL)) ctrl <= bus_wdata[1:0];
      // A new overrun on the same edge as the clear keeps the flag set.
      rx_overrun <= ovr_set | (rx_overrun & ~ovr_clr);
      irq <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
             (ctrl[CTRL_TX_IRQ_EN] & tx_empty) |
             rx_overrun;
    end
  end

  // TX launch FSM; GUARD skips one cycle because the UART lowers ready only
  // on the edge after it sees the launch strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state      <= TX_IDLE;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      uart_tx_valid <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state      <= TX_LAUNCH;
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= tx_head;
          end
        end
        TX_LAUNCH: tx_state <= TX_GUARD;
        TX_GUARD:  tx_state <= TX_WAIT;
        TX_WAIT:   if (uart_tx_ready) tx_state <= TX_IDLE;
        default:   tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_uart_ctrl.sv
module tb_rv32i_uart_ctrl;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel, bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic        irq;

  always #5 clk = ~clk;

  rv32i_uart_ctrl #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_sel       (bus_sel),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ready     (bus_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .irq           (irq)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_sent[$];
  int         tx_pend;
  logic       overrun_m;
  logic [1:0] ctrl_m;

  // UART line model: busy for a while after each launch
  logic [7:0] tx_log[$];
  bit busy = 0;
  int busy_cnt = 0;
  int busy_len = 0;
  bit hold = 0;
  int viol = 0;

  assign uart_tx_ready = !busy && !hold;

  always @(negedge clk) begin
    if (uart_tx_valid) begin
      tx_log.push_back(uart_tx_data);
      if (busy || hold) viol++;
      busy = 1;
      busy_cnt = (busy_len != 0) ? busy_len : int'($urandom_range(1, 5));
    end else if (busy) begin
      busy_cnt--;
      if (busy_cnt <= 0) busy = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (tx_pend == DEPTH);
    s[1] = (tx_pend == 0);
    s[2] = (rx_q.size() == 0);
    s[3] = (rx_q.size() == DEPTH);
    s[4] = overrun_m;
    s[5] = (tx_pend == 0);
    s[15:8] = 8'(rx_q.size());
    return s;
  endfunction

  function automatic logic exp_irq();
    return (ctrl_m[0] && rx_q.size() != 0) || (ctrl_m[1] && tx_pend == 0) || overrun_m;
  endfunction

  task automatic model_reset();
    rx_q.delete();
    tx_sent.delete();
    tx_pend = 0;
    overrun_m = 0;
    ctrl_m = 0;
  endtask

  task automatic bus(input bit we, input logic [1:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    bus_sel = 1; bus_we = we; bus_addr = a; bus_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    chk("bus_ready", {31'b0, bus_ready}, 32'd1);
    rd = bus_rdata;
    bus_sel = 0; bus_we = 0; bus_wdata = 0;
  endtask

  task automatic wr_data(input logic [7:0] b);
    logic [31:0] rd;
    bus(1, 2'd0, {$urandom_range(0, 255), 16'h0, b} , rd);
    if (tx_pend < DEPTH) begin
      tx_sent.push_back(b);
      tx_pend++;
    end
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] rd, e;
    e = 0;
    if (rx_q.size() != 0) e = {24'b0, rx_q.pop_front()};
    bus(0, 2'd0, 32'h0, rd);
    chk(tag, rd, e);
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    logic [31:0] rd;
    bus(1, 2'd2, v, rd);
    ctrl_m = v[1:0];
  endtask

  task automatic rx_push(input logic [7:0] b);
    uart_rx_valid = 1; uart_rx_data = b;
    @(negedge clk);
    uart_rx_valid = 0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else overrun_m = 1;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] rd;
    bus(0, 2'd1, 32'h0, rd);
    chk({"status_", tag}, rd, exp_status());
    chk({"irq_", tag}, {31'b0, irq}, {31'b0, exp_irq()});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({"rst_ready_", tag}, {31'b0, bus_ready}, 32'd0);
    chk({"rst_rdata_", tag}, bus_rdata, 32'd0);
    chk({"rst_txv_", tag}, {31'b0, uart_tx_valid}, 32'd0);
    chk({"rst_txd_", tag}, {24'b0, uart_tx_data}, 32'd0);
    chk({"rst_irq_", tag}, {31'b0, irq}, 32'd0);
  endtask

  task automatic wait_tx_compare(input string tag);
    int n, i;
    n = tx_sent.size();
    i = 0;
    while (tx_log.size() < n && i < 1000) begin
      @(negedge clk);
      i++;
    end
    repeat (12) @(negedge clk);
    chk({tag, "_count"}, tx_log.size(), n);
    for (int k = 0; k < n && k < tx_log.size(); k++)
      chk({tag, "_byte"}, {24'b0, tx_log[k]}, {24'b0, tx_sent[k]});
    tx_log.delete();
    tx_sent.delete();
    tx_pend = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b0;
    int          n;
    int          i;

    rst = 1; bus_sel = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
    uart_rx_valid = 0; uart_rx_data = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 0;
    @(negedge clk);
    check_status("after_reset");

    // Two directed TX bytes
    wr_data(8'h41);
    wr_data(8'h42);
    wait_tx_compare("tx_basic");
    check_status("tx_basic_done");

    // Random TX burst
    n = $urandom_range(3, 6);
    for (int k = 0; k < n; k++) wr_data(8'($urandom));
    wait_tx_compare("tx_rand");

    // Fill TX while the UART holds ready low; extra writes are dropped
    hold = 1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) wr_data(8'($urandom));
    check_status("tx_full");
    hold = 0;
    wait_tx_compare("tx_full_drain");
    check_status("tx_full_done");

    // Single RX byte
    rx_push(8'h55);
    check_status("rx_one");
    rd_data("rx_one_data");
    check_status("rx_one_empty");
    rd_data("rx_empty_data");

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int k = 0; k < DEPTH + 1; k++) rx_push(8'($urandom));
    check_status("rx_overrun");
    bus(1, 2'd1, 32'h0000_0010, rd);
    overrun_m = 0;
    check_status("rx_w1c");
    for (int k = 0; k < DEPTH; k++) rd_data("rx_ovr_drain");
    check_status("rx_ovr_drained");

    // Same-edge pop and push on a full RX FIFO
    for (int k = 0; k < DEPTH; k++) rx_push(8'($urandom));
    rd = 0;
    begin
      logic [31:0] e;
      e = {24'b0, rx_q.pop_front()};
      rx_q.push_back(8'hAA);
      uart_rx_valid = 1; uart_rx_data = 8'hAA;
      bus(0, 2'd0, 32'h0, rd);
      uart_rx_valid = 0;
      chk("rx_pop_push_data", rd, e);
    end
    check_status("rx_pop_push");
    for (int k = 0; k < DEPTH; k++) rd_data("rx_pp_drain");

    // Interrupts and CTRL
    wr_ctrl(32'h0000_0001);
    bus(0, 2'd2, 32'h0, rd);
    chk("ctrl_rd1", rd, 32'h1);
    check_status("irq_rx_off");
    rx_push(8'($urandom));
    chk("irq_same_cycle", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_next_cycle", {31'b0, irq}, 32'd1);
    rd_data("irq_drain");
    check_status("irq_rx_drained");
    wr_ctrl(32'hFFFF_FFFE);
    bus(0, 2'd2, 32'h0, rd);
    chk("ctrl_rd2", rd, 32'h2);
    check_status("irq_tx_empty");
    bus(1, 2'd3, 32'hFFFF_FFFF, rd);
    bus(0, 2'd3, 32'h0, rd);
    chk("rsvd_rd", rd, 32'h0);
    wr_ctrl(32'h0);
    check_status("ctrl_off");

    // Reset while waiting on the UART with bytes queued
    busy_len = 40;
    b0 = 8'($urandom);
    wr_data(b0);
    i = 0;
    while (tx_log.size() < 1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("wait_launch", tx_log.size(), 1);
    for (int k = 0; k < 3; k++) wr_data(8'($urandom));
    repeat (4) @(negedge clk);
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_tx");
    rst = 0;
    busy_len = 0;
    repeat (60) @(negedge clk);
    chk("post_rst_no_launch", tx_log.size(), 1);
    if (tx_log.size() != 0) chk("post_rst_first_byte", {24'b0, tx_log[0]}, {24'b0, b0});
    tx_log.delete();
    check_status("post_rst");

    chk("tx_protocol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
